// File: rtl/ram_burst_ctrl_if.sv
// ram_burst_ctrl_if
// Client-side bundle for ram_burst_ctrl: command port, write-beat stream
// and read-beat stream, plus the busy flag.
//   slave  : seen by the controller (takes commands, produces read beats)
//   master : seen by the client (issues commands, consumes read beats)
interface ram_burst_ctrl_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) ();
    logic                  i_cmd_valid;
    logic                  o_cmd_ready;
    logic                  i_cmd_write;
    logic [ADDR_WIDTH-1:0] i_cmd_addr;
    logic [LEN_WIDTH-1:0]  i_cmd_len;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic                  i_wvalid;
    logic                  o_wready;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic                  o_rvalid;
    logic                  o_busy;

    modport slave (
        input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_len, i_wdata, i_wvalid,
        output o_cmd_ready, o_wready, o_rdata, o_rvalid, o_busy
    );

    modport master (
        output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_len, i_wdata, i_wvalid,
        input  o_cmd_ready, o_wready, o_rdata, o_rvalid, o_busy
    );
endinterface

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl
// Burst access controller in front of a single-port RAM with a one-cycle
// registered read and a shared bidirectional data bus. Accepts read/write
// bursts of 1..2^LEN_WIDTH beats, auto-increments (and wraps) the address.
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   bus (slave)     : command, write-beat and read-beat streams, busy
//   o_ram_cs/wr_e/oe: RAM chip select, write enable, output enable
//   o_ram_address   : RAM address
//   io_ram_data     : RAM data bus, driven here only on accepted write beats
module ram_burst_ctrl #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    ram_burst_ctrl_if.slave       bus,
    output logic                  o_ram_cs,
    output logic                  o_ram_wr_e,
    output logic                  o_ram_oe,
    output logic [ADDR_WIDTH-1:0] o_ram_address,
    inout  wire  [DATA_WIDTH-1:0] io_ram_data
);
    typedef enum logic [1:0] {IDLE, WR_BEAT, RD_ADDR, RD_DATA} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [LEN_WIDTH-1:0]  CNT_ONE  = 1;
    localparam logic [LEN_WIDTH-1:0]  CNT_ZERO = '0;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  data_drive;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // RAM controls decode from state_q only (plus i_wvalid in WR_BEAT) so
    // an async reset drops them immediately.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        count_d         = count_q;
        rdata_d         = rdata_q;
        rvalid_d        = 1'b0;
        o_ram_cs        = 1'b0;
        o_ram_wr_e      = 1'b0;
        o_ram_oe        = 1'b0;
        data_drive      = 1'b0;
        bus.o_cmd_ready = 1'b0;
        bus.o_wready    = 1'b0;
        bus.o_busy      = 1'b1;

        case (state_q)
            IDLE: begin
                bus.o_cmd_ready = 1'b1;
                bus.o_busy      = 1'b0;
                if (bus.i_cmd_valid) begin
                    addr_d  = bus.i_cmd_addr;
                    count_d = bus.i_cmd_len;
                    state_d = bus.i_cmd_write ? WR_BEAT : RD_ADDR;
                end
            end
            WR_BEAT: begin
                bus.o_wready = 1'b1;
                o_ram_wr_e   = 1'b1;
                // A gap in i_wvalid deselects the RAM so nothing is written.
                o_ram_cs     = bus.i_wvalid;
                data_drive   = bus.i_wvalid;
                if (bus.i_wvalid) begin
                    addr_d  = addr_q + ADDR_ONE;
                    count_d = count_q - CNT_ONE;
                    if (count_q == CNT_ZERO) state_d = IDLE;
                end
            end
            RD_ADDR: begin
                // RAM registers the word at the end of this cycle.
                o_ram_cs = 1'b1;
                state_d  = RD_DATA;
            end
            RD_DATA: begin
                o_ram_cs = 1'b1;
                o_ram_oe = 1'b1;
                rdata_d  = io_ram_data;
                rvalid_d = 1'b1;
                addr_d   = addr_q + ADDR_ONE;
                count_d  = count_q - CNT_ONE;
                state_d  = (count_q == CNT_ZERO) ? IDLE : RD_ADDR;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_ram_address = addr_q;
    assign io_ram_data   = data_drive ? bus.i_wdata : {DATA_WIDTH{1'bz}};
    assign bus.o_rdata   = rdata_q;
    assign bus.o_rvalid  = rvalid_q;

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
Command-driven access controller that sits directly upstream of the 128x8 single-port RAM and drives its chip-select, write-enable, output-enable, address and bidirectional data bus. A client issues read or write bursts of 1-16 bytes through a valid/ready command port. The controller sequences the RAM's one-cycle registered read and tristate turnaround, auto-increments the address, and streams write data in and read data out.

Parameters:
ADDR_WIDTH, 7, RAM address width; address wraps modulo 2^ADDR_WIDTH
DATA_WIDTH, 8, RAM data width
LEN_WIDTH, 4, burst length field; beats = i_cmd_len+1

Ports:
i_clk  in  1  clock; all state changes on the rising edge
i_rst_n  in  1  asynchronous active-low reset
i_cmd_valid  in  1  command request
o_cmd_ready  out  1  command accepted when valid&ready
i_cmd_write  in  1  1=write burst, 0=read burst
i_cmd_addr  in  ADDR_WIDTH  start address
i_cmd_len  in  LEN_WIDTH  beats minus one
i_wdata  in  DATA_WIDTH  write beat data
i_wvalid  in  1  write beat valid
o_wready  out  1  write beat accepted when wvalid&wready
o_rdata  out  DATA_WIDTH  read beat data
o_rvalid  out  1  one-cycle pulse per read beat; no backpressure
o_busy  out  1  burst in progress
o_ram_cs  out  1  RAM chip select
o_ram_wr_e  out  1  RAM write enable
o_ram_oe  out  1  RAM output enable
o_ram_address  out  ADDR_WIDTH  RAM address
io_ram_data  inout  DATA_WIDTH  RAM data bus; driven by this block only during write beats

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_ram_cs/wr_e/oe=0; o_ram_address=0; io_ram_data released (Z); o_rvalid=0; o_rdata=0; o_busy=0; o_wready=0; o_cmd_ready=1.
- States: IDLE, WR_BEAT, RD_ADDR, RD_DATA. The address register and beat counter are loaded on command accept.
- IDLE: o_cmd_ready=1, o_busy=0. On i_cmd_valid, latch addr, count=i_cmd_len and direction. Go to WR_BEAT if write, else RD_ADDR.
- WR_BEAT: o_wready=1, o_ram_wr_e=1, o_ram_oe=0, o_ram_cs=i_wvalid, io_ram_data=i_wdata while i_wvalid, else Z.
  - On each accepted beat: addr+1, count-1.
  - The beat with count==0 returns the block to IDLE.
  - Gaps in i_wvalid produce no RAM write and no counter change.
- RD_ADDR: o_ram_cs=1, o_ram_wr_e=0, o_ram_oe=0, address=addr reg. The RAM registers the word at the end of this cycle. Next state is RD_DATA.
- RD_DATA: o_ram_cs=1, o_ram_wr_e=0, o_ram_oe=1, same address.
  - At the closing edge: o_rdata<=io_ram_data, o_rvalid<=1 for one cycle, addr+1, count-1.
  - Next state is IDLE if count was 0, else RD_ADDR.
- Read latency: command accepted at edge T; o_rvalid is high in the cycle following edge T+2. Beats are spaced 2 cycles apart; a 16-beat read takes 32 cycles.
- o_busy=1 in all states except IDLE. o_cmd_ready=0 while busy; commands presented while busy are ignored, not queued.
- Back-to-back commands: at least one IDLE cycle separates bursts.
- Address wrap: 127 increments to 0 within a burst. No error is flagged.
- Bus safety invariants:
  - o_ram_oe=1 implies o_ram_wr_e=0.
  - This block drives io_ram_data only when o_ram_wr_e=1 and i_wvalid=1.
  - Bus contention is never permitted.
- RAM control outputs decode from the state register (plus i_wvalid in WR_BEAT) so they return to reset values immediately on async reset.
- Reset mid-burst: the burst is abandoned and no further o_rvalid is issued. Partially written bytes remain in RAM. After release the block is in IDLE.

Test Plan:
1. Hold i_rst_n=0, then release -> all RAM controls 0, io_ram_data=Z, o_cmd_ready=1, o_busy=0, o_rvalid=0.
2. Single write addr 0x10 data 0xA5 (len 0), then single read addr 0x10 -> o_rdata=0xA5; o_rvalid pulses one cycle, in the cycle after the 2nd edge following accept.
3. Write burst addr 0x7E len 3 data 0x11,0x22,0x33,0x44 -> RAM writes at 0x7E,0x7F,0x00,0x01. Read burst addr 0x7E len 3 -> o_rdata 0x11,0x22,0x33,0x44 with o_rvalid pulses 2 cycles apart.
4. Write burst len 2 with i_wvalid low for 3 cycles between beats -> o_ram_cs low during gaps; exactly 3 writes at consecutive addresses; o_busy falls after the 3rd beat.
5. Assert i_cmd_valid continuously during a 16-beat read -> only the first command accepted; the next is accepted only after one IDLE cycle. Assertion checker confirms oe&wr_e never both high and io_ram_data is never driven by both sides.
6. Pull i_rst_n low during RD_DATA of beat 2 of a 4-beat read -> controls drop to 0 asynchronously, io_ram_data=Z, no further o_rvalid. A fresh command after release completes normally.
